store_buffer_ctrl: RTL and testbench
====================================

// Module: store_buffer_ctrl
// PURPOSE
//  Load/store front end sitting directly upstream of the data memory. Accepts one
//  load or store request per cycle from the execute stage and posts stores into a
//  DEPTH-entry FIFO. Stores drain to memory when the port is free. Loads are
//  forwarded from the FIFO (youngest match) or read from memory.
// PARAMETERS
//  DEPTH   4   store-buffer entries (power of 2, >=2)
//  ADDR_W  10  word address width
//  DATA_W  32  data width
// PORTS
//  clk        in   1                 system clock, rising edge
//  reset      in   1                 synchronous, active-low (reset==0 resets)
//  req_valid  in   1                 request present
//  req_write  in   1                 1=store, 0=load
//  req_addr   in   ADDR_W            word address
//  req_wdata  in   DATA_W            store data
//  req_ready  out  1                 request accepted when req_valid&req_ready
//  rsp_valid  out  1                 one-cycle pulse: load data valid
//  rsp_rdata  out  DATA_W            load data
//  buf_count  out  $clog2(DEPTH+1)   occupied entries
//  buf_empty  out  1                 buf_count==0
//  mem_read   out  1                 memory read strobe
//  mem_write  out  1                 memory write strobe
//  mem_addr   out  ADDR_W            memory address
//  mem_wdata  out  DATA_W            memory write data
//  mem_rdata  in   DATA_W            memory read data, valid cycle after mem_read
// BEHAVIOUR
//  Reset (reset==0 at a clk edge): state IDLE, head=tail=0, count=0, all entries
//   invalid, rsp_valid=0, rsp_rdata=0. While reset==0: req_ready=0, mem_read=0,
//   mem_write=0. Buffered stores and pending load responses are discarded.
//  FSM: IDLE, LOAD_WAIT.
//  req_ready = (state==IDLE) && (count<DEPTH) && reset.
//  Store accept: push {addr,data} at tail; tail=(tail+1)%DEPTH. Wraps silently.
//  Load accept, forward hit: compare req_addr with all valid entries. Youngest
//   match supplies the data. rsp_valid=1 with that data at the next cycle
//   (latency 1). No mem_read. State stays IDLE.
//  Load accept, miss: same cycle mem_read=1, mem_addr=req_addr, mem_write=0.
//   Go to LOAD_WAIT. In LOAD_WAIT, register mem_rdata into rsp_rdata and return
//   to IDLE. rsp_valid pulses the cycle after that (latency 2).
//  Drain: mem_write=1, mem_addr/mem_wdata=head entry when
//   count>0 && !(load-miss issue this cycle) &&
//   (state==LOAD_WAIT || !req_valid || count==DEPTH).
//   Head pops at that edge; head=(head+1)%DEPTH.
//  Push and pop in the same cycle: count unchanged; both pointers advance.
//  mem_read and mem_write are never high together. Memory writes occur in exact
//   store order.
//  Full: req_ready=0. The next cycle drains, then accepts.
//  rsp_valid only ever follows an accepted load. At most one load is outstanding.
//  mem_addr/mem_wdata are 0 when neither strobe is high.
// TESTING
//  1 reset=0 for 2 cycles with req_valid=1 -> req_ready=0, strobes 0,
//    rsp_valid=0, buf_count=0, buf_empty=1.
//  2 Store 0x005<-0xDEADBEEF, then req_valid=0 -> next cycle mem_write=1,
//    addr 0x005, data 0xDEADBEEF; buf_count 1->0.
//  3 Back-to-back stores 0x010<-0x11111111, 0x010<-0x22222222, then load 0x010
//    -> rsp_valid next cycle with 0x22222222; mem_read never asserted.
//  4 Buffer empty, memory[0x020]=0xCAFEF00D, load 0x020 at T -> mem_read at T
//    with addr 0x020; rsp_valid at T+2 with 0xCAFEF00D.
//  5 req_valid held with 6 stores (addr 1..6, data 0xA1..0xA6) -> 4 accepted,
//    req_ready=0, a drain occurs, then the rest are accepted. Pointers wrap.
//    Memory sees writes 1..6 in order.
//  6 3 stores buffered, reset=0 one cycle -> buf_count=0; no further mem_write
//    for the discarded entries; the next load misses.

Source files
------------

// File: rtl/store_buffer_ctrl.sv
// store_buffer_ctrl: posted-store FIFO in front of data memory with youngest-match
// load forwarding and a single outstanding load miss.
module store_buffer_ctrl #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  input  logic                       req_write,
  input  logic [ADDR_W-1:0]          req_addr,
  input  logic [DATA_W-1:0]          req_wdata,
  output logic                       req_ready,
  output logic                       rsp_valid,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic [$clog2(DEPTH+1)-1:0] buf_count,
  output logic                       buf_empty,
  output logic                       mem_read,
  output logic                       mem_write,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic [DATA_W-1:0]          mem_rdata
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  typedef enum logic {IDLE, LOAD_WAIT} state_t;
  state_t              state_q, state_d;
  logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d, idx;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [DEPTH-1:0]    vld_q, vld_d;
  logic [ADDR_W-1:0]   ent_addr_q [DEPTH];
  logic [ADDR_W-1:0]   ent_addr_d [DEPTH];
  logic [DATA_W-1:0]   ent_data_q [DEPTH];
  logic [DATA_W-1:0]   ent_data_d [DEPTH];
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d, fwd_data;
  logic                accept, push, ld, hit, miss, pop;
  // Scan oldest to youngest so the last match found is the youngest store.
  always_comb begin
    hit = 1'b0;
    fwd_data = '0;
    idx = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (vld_q[idx] && ent_addr_q[idx] == req_addr) begin
        hit = 1'b1;
        fwd_data = ent_data_q[idx];
      end
    end
  end
  assign req_ready = (state_q == IDLE) && (count_q < CNT_W'(DEPTH)) && reset;
  assign accept    = req_valid && req_ready;
  assign push      = accept && req_write;
  assign ld        = accept && !req_write;
  assign miss      = ld && !hit;
  assign pop       = reset && (count_q != '0) && !miss &&
                     (state_q == LOAD_WAIT || !req_valid || count_q == CNT_W'(DEPTH));
  assign mem_read  = miss;
  assign mem_write = pop;
  assign mem_addr  = miss ? req_addr : pop ? ent_addr_q[head_q] : '0;
  assign mem_wdata = pop ? ent_data_q[head_q] : '0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign buf_count = count_q;
  assign buf_empty = count_q == '0;
  always_comb begin
    state_d = (state_q == IDLE && miss) ? LOAD_WAIT : IDLE;
    head_d = head_q + PTR_W'(pop);
    tail_d = tail_q + PTR_W'(push);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    vld_d = vld_q;
    ent_addr_d = ent_addr_q;
    ent_data_d = ent_data_q;
    if (pop) vld_d[head_q] = 1'b0;
    if (push) begin
      vld_d[tail_q] = 1'b1;
      ent_addr_d[tail_q] = req_addr;
      ent_data_d[tail_q] = req_wdata;
    end
    rsp_valid_d = (state_q == LOAD_WAIT) || (ld && hit);
    rsp_rdata_d = (state_q == LOAD_WAIT) ? mem_rdata : (ld && hit) ? fwd_data : rsp_rdata_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      vld_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      vld_q <= vld_d;
      ent_addr_q <= ent_addr_d;
      ent_data_q <= ent_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end
endmodule

// File: tb/tb_store_buffer_ctrl.sv
// tb_store_buffer_ctrl: queue-based reference model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_store_buffer_ctrl;
  localparam int DEPTH = 4;
  logic        clk = 1'b0;
  logic        reset, req_valid, req_write, req_ready, rsp_valid;
  logic [9:0]  req_addr, mem_addr;
  logic [31:0] req_wdata, rsp_rdata, mem_wdata, mem_rdata;
  logic [2:0]  buf_count;
  logic        buf_empty, mem_read, mem_write;
  int checks = 0, errors = 0;
  bit chk_en = 0;

  store_buffer_ctrl #(.DEPTH(DEPTH), .ADDR_W(10), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .buf_count(buf_count),
    .buf_empty(buf_empty), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", n, got, exp, $time);
    end
  endtask

  // Memory environment: read data returns the cycle after mem_read.
  logic [31:0] mem [1024];
  typedef struct packed {logic [9:0] a; logic [31:0] d;} ent_t;
  ent_t wlog[$];
  int nreads = 0;
  always @(posedge clk) begin
    if (mem_read) begin
      mem_rdata <= mem[mem_addr];
      nreads++;
    end
    if (mem_write) begin
      mem[mem_addr] = mem_wdata;
      wlog.push_back({mem_addr, mem_wdata});
    end
  end

  // Reference model: stores as an in-order queue, one pending-load flag.
  ent_t sb[$];
  bit waiting = 0, m_rv = 0;
  logic [31:0] m_rd = '0;
  typedef struct packed {
    logic ready, acc, hit, mr, mw;
    logic [9:0] ma;
    logic [31:0] hd, md;
  } exp_t;

  function automatic exp_t model_eval();
    exp_t r;
    int n;
    n = sb.size();
    r = '0;
    r.ready = reset && !waiting && n < DEPTH;
    r.acc = req_valid && r.ready;
    for (int k = 0; k < n; k++)
      if (sb[k].a == req_addr) begin
        r.hit = 1'b1;
        r.hd = sb[k].d;
      end
    r.mr = r.acc && !req_write && !r.hit;
    r.mw = reset && n > 0 && !r.mr && (waiting || !req_valid || n == DEPTH);
    r.ma = r.mr ? req_addr : r.mw ? sb[0].a : '0;
    r.md = r.mw ? sb[0].d : '0;
    return r;
  endfunction

  exp_t e_upd, e_cmp;
  always @(posedge clk) begin
    e_upd = model_eval();
    if (!reset) begin
      sb.delete();
      waiting = 0;
      m_rv = 0;
      m_rd = '0;
    end else begin
      m_rv = 0;
      if (waiting) begin
        m_rv = 1;
        m_rd = mem_rdata;
        waiting = 0;
      end
      if (e_upd.mw) void'(sb.pop_front());
      if (e_upd.acc && req_write) sb.push_back({req_addr, req_wdata});
      if (e_upd.acc && !req_write) begin
        if (e_upd.hit) begin
          m_rv = 1;
          m_rd = e_upd.hd;
        end else waiting = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      e_cmp = model_eval();
      chk("req_ready", 32'(req_ready), 32'(e_cmp.ready));
      chk("mem_read", 32'(mem_read), 32'(e_cmp.mr));
      chk("mem_write", 32'(mem_write), 32'(e_cmp.mw));
      chk("mem_addr", 32'(mem_addr), 32'(e_cmp.ma));
      chk("mem_wdata", mem_wdata, e_cmp.md);
      chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
      chk("rsp_rdata", rsp_rdata, m_rd);
      chk("buf_count", 32'(buf_count), sb.size());
      chk("buf_empty", 32'(buf_empty), 32'(sb.size() == 0));
    end
  end

  task automatic apply(input logic rst, input logic rv, input logic rw,
                       input logic [9:0] a, input logic [31:0] d);
    reset = rst;
    req_valid = rv;
    req_write = rw;
    req_addr = a;
    req_wdata = d;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int i, guard, r0;
    bit saw_full;
    mem[10'h020] = 32'hCAFEF00D;
    mem[10'h030] = 32'h00000055;
    reset = 0; req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
    tick;
    chk_en = 1;
    // reset held with a request pending
    apply(0, 1, 1, 10'h003, 32'h1);
    chk("t1_ready", 32'(req_ready), 0);
    chk("t1_mem_write", 32'(mem_write), 0);
    chk("t1_mem_read", 32'(mem_read), 0);
    tick;
    apply(0, 1, 1, 10'h003, 32'h1);
    chk("t1_rsp_valid", 32'(rsp_valid), 0);
    chk("t1_count", 32'(buf_count), 0);
    chk("t1_empty", 32'(buf_empty), 1);
    tick;
    // single store then drain
    apply(1, 1, 1, 10'h005, 32'hDEADBEEF);
    chk("t2_ready", 32'(req_ready), 1);
    tick;
    apply(1, 0, 0, 10'h0, 32'h0);
    chk("t2_mem_write", 32'(mem_write), 1);
    chk("t2_mem_addr", 32'(mem_addr), 32'h005);
    chk("t2_mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("t2_count1", 32'(buf_count), 1);
    tick;
    apply(1, 0, 0, 10'h0, 32'h0);
    chk("t2_count0", 32'(buf_count), 0);
    tick;
    // youngest-match forwarding
    r0 = nreads;
    apply(1, 1, 1, 10'h010, 32'h11111111); tick;
    apply(1, 1, 1, 10'h010, 32'h22222222); tick;
    apply(1, 1, 0, 10'h010, 32'h0);
    chk("t3_no_read", 32'(mem_read), 0);
    tick;
    apply(1, 0, 0, 10'h0, 32'h0);
    chk("t3_rsp_valid", 32'(rsp_valid), 1);
    chk("t3_rsp_rdata", rsp_rdata, 32'h22222222);
    tick;
    repeat (2) begin apply(1, 0, 0, 10'h0, 32'h0); tick; end
    chk("t3_nreads", nreads, r0);
    chk("t3_empty", 32'(buf_empty), 1);
    // load miss, latency 2
    apply(1, 1, 0, 10'h020, 32'h0);
    chk("t4_mem_read", 32'(mem_read), 1);
    chk("t4_mem_addr", 32'(mem_addr), 32'h020);
    tick;
    apply(1, 0, 0, 10'h0, 32'h0);
    chk("t4_rsp_early", 32'(rsp_valid), 0);
    chk("t4_wait_ready", 32'(req_ready), 0);
    tick;
    apply(1, 0, 0, 10'h0, 32'h0);
    chk("t4_rsp_valid", 32'(rsp_valid), 1);
    chk("t4_rsp_rdata", rsp_rdata, 32'hCAFEF00D);
    tick;
    // overflow with req_valid held, pointer wrap
    wlog.delete();
    i = 1; guard = 0; saw_full = 0;
    while (i <= 6 && guard < 30) begin
      apply(1, 1, 1, 10'(i), 32'hA0 + 32'(i));
      if (req_ready) i++;
      else saw_full = 1;
      tick;
      guard++;
    end
    chk("t5_all_accepted", i, 7);
    chk("t5_saw_full", 32'(saw_full), 1);
    repeat (6) begin apply(1, 0, 0, 10'h0, 32'h0); tick; end
    chk("t5_nwrites", wlog.size(), 6);
    for (int k = 0; k < wlog.size() && k < 6; k++) begin
      chk("t5_wr_addr", 32'(wlog[k].a), k + 1);
      chk("t5_wr_data", wlog[k].d, 32'hA1 + 32'(k));
    end
    // reset discards buffered stores
    wlog.delete();
    for (int k = 0; k < 3; k++) begin apply(1, 1, 1, 10'h030 + 10'(k), 32'(k + 1)); tick; end
    apply(0, 0, 0, 10'h0, 32'h0);
    chk("t6_rst_count3", 32'(buf_count), 3);
    chk("t6_rst_mem_write", 32'(mem_write), 0);
    tick;
    apply(1, 0, 0, 10'h0, 32'h0);
    chk("t6_count", 32'(buf_count), 0);
    chk("t6_empty", 32'(buf_empty), 1);
    tick;
    repeat (3) begin apply(1, 0, 0, 10'h0, 32'h0); tick; end
    chk("t6_no_writes", wlog.size(), 0);
    apply(1, 1, 0, 10'h030, 32'h0);
    chk("t6_miss", 32'(mem_read), 1);
    chk("t6_miss_addr", 32'(mem_addr), 32'h030);
    tick;
    apply(1, 0, 0, 10'h0, 32'h0); tick;
    apply(1, 0, 0, 10'h0, 32'h0);
    chk("t6_rsp_valid", 32'(rsp_valid), 1);
    chk("t6_rsp_rdata", rsp_rdata, 32'h55);
    tick;
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
